// File: rtl/gray_ptr_sync.sv
// ============================================================================
//  Module   : gray_ptr_sync
//  Brief    : Two-flop synchronizer for a Gray-coded FIFO pointer with a
//             configurable reset value, so the receiving side sees the
//             correct pointer from the first cycle after reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_ptr_sync #(
    parameter int            PTR_WIDTH = 6,
    parameter logic [PTR_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PTR_WIDTH-1:0] i_gray,
    output logic [PTR_WIDTH-1:0] o_gray
);

    logic [PTR_WIDTH-1:0] r_meta;
    logic [PTR_WIDTH-1:0] r_sync;

    // Two capture stages; both reset to the opposite side's reset-time pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_gray;
            r_sync <= r_meta;
        end
    end

    assign o_gray = r_sync;

endmodule

`default_nettype wire

// File: rtl/async_fifo.sv
// ============================================================================
//  Module   : async_fifo
//  Brief    : FIFO with registered read data and Gray-coded pointers crossing
//             between write and read sides through 2-flop synchronizers.
//             Optionally reports BOOT_COUNT valid entries right after reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module async_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH      = 32,
    parameter int BOOT_COUNT = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [WIDTH-1:0]             i_wr_data,
    output logic                         o_wr_full,
    output logic                         o_wr_almost_full,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_rd_data,
    output logic                         o_rd_empty,
    output logic [$clog2(DEPTH):0]       o_rd_count
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PW         = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] f_bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] f_gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [PW-1:0] c_boot_ptr  = PW'(BOOT_COUNT);
    localparam logic [PW-1:0] c_boot_gray = f_bin2gray(c_boot_ptr);
    localparam logic [PW-1:0] c_depth     = PW'(DEPTH);
    localparam logic [PW-1:0] c_almost    = PW'(DEPTH - 2);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wr_bin;
    logic [PW-1:0] r_wr_gray;
    logic [PW-1:0] r_rd_bin;
    logic [PW-1:0] r_rd_gray;

    logic [PW-1:0] w_wr_gray_sync;
    logic [PW-1:0] w_rd_gray_sync;
    logic [PW-1:0] w_wr_bin_sync;
    logic [PW-1:0] w_rd_bin_sync;
    logic [PW-1:0] w_wr_count;
    logic [PW-1:0] w_rd_count;
    logic [PW-1:0] w_wr_bin_next;
    logic [PW-1:0] w_rd_bin_next;
    logic          w_wr_fire;
    logic          w_rd_fire;

    assign w_wr_fire     = i_wr_en && !o_wr_full;
    assign w_rd_fire     = i_rd_en && !o_rd_empty;
    assign w_wr_bin_next = r_wr_bin + PW'(1);
    assign w_rd_bin_next = r_rd_bin + PW'(1);

    // Write pointer: binary and Gray copies advance together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bin  <= c_boot_ptr;
            r_wr_gray <= c_boot_gray;
        end else if (w_wr_fire) begin
            r_wr_bin  <= w_wr_bin_next;
            r_wr_gray <= f_bin2gray(w_wr_bin_next);
        end
    end

    // Storage array; intentionally not reset so contents survive as data only.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bin[ADDR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    // Read pointer and registered read data; data holds when nothing is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bin  <= '0;
            r_rd_gray <= '0;
            o_rd_data <= '0;
        end else if (w_rd_fire) begin
            r_rd_bin  <= w_rd_bin_next;
            r_rd_gray <= f_bin2gray(w_rd_bin_next);
            o_rd_data <= r_mem[r_rd_bin[ADDR_WIDTH-1:0]];
        end
    end

    gray_ptr_sync #(
        .PTR_WIDTH (PW),
        .RESET_VAL (c_boot_gray)
    ) u_wr2rd_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_gray (r_wr_gray),
        .o_gray (w_wr_gray_sync)
    );

    gray_ptr_sync #(
        .PTR_WIDTH (PW),
        .RESET_VAL ('0)
    ) u_rd2wr_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_gray (r_rd_gray),
        .o_gray (w_rd_gray_sync)
    );

    assign w_wr_bin_sync = f_gray2bin(w_wr_gray_sync);
    assign w_rd_bin_sync = f_gray2bin(w_rd_gray_sync);

    // Each side counts against the delayed view of the other pointer, so the
    // flags can only understate what is available.
    assign w_wr_count       = r_wr_bin - w_rd_bin_sync;
    assign w_rd_count       = w_wr_bin_sync - r_rd_bin;
    assign o_wr_full        = (w_wr_count == c_depth);
    assign o_wr_almost_full = (w_wr_count >= c_almost);
    assign o_rd_empty       = (w_rd_count == '0);
    assign o_rd_count       = w_rd_count;

endmodule

`default_nettype wire

// File: tb/tb_async_fifo.sv
`default_nettype none

module tb_async_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with BOOT_COUNT = 0
    logic        rst0_n = 1'b0;
    logic        wr_en0 = 1'b0, rd_en0 = 1'b0;
    logic [71:0] wr_data0 = '0;
    logic        wr_full0, wr_af0, rd_empty0;
    logic [71:0] rd_data0;
    logic [5:0]  rd_count0;

    // Instance with BOOT_COUNT = 5
    logic        rst5_n = 1'b0;
    logic        wr_en5 = 1'b0, rd_en5 = 1'b0;
    logic [71:0] wr_data5 = '0;
    logic        wr_full5, wr_af5, rd_empty5;
    logic [71:0] rd_data5;
    logic [5:0]  rd_count5;

    async_fifo #(.WIDTH(72), .DEPTH(32), .BOOT_COUNT(0)) u_dut0 (
        .clk(clk), .rst_n(rst0_n),
        .i_wr_en(wr_en0), .i_wr_data(wr_data0),
        .o_wr_full(wr_full0), .o_wr_almost_full(wr_af0),
        .i_rd_en(rd_en0), .o_rd_data(rd_data0),
        .o_rd_empty(rd_empty0), .o_rd_count(rd_count0)
    );

    async_fifo #(.WIDTH(72), .DEPTH(32), .BOOT_COUNT(5)) u_dut5 (
        .clk(clk), .rst_n(rst5_n),
        .i_wr_en(wr_en5), .i_wr_data(wr_data5),
        .o_wr_full(wr_full5), .o_wr_almost_full(wr_af5),
        .i_rd_en(rd_en5), .o_rd_data(rd_data5),
        .o_rd_empty(rd_empty5), .o_rd_count(rd_count5)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [71:0] q0[$];
    logic [71:0] last0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr0(input logic [71:0] d, input bit accept);
        wr_en0   = 1'b1;
        wr_data0 = d;
        tick();
        wr_en0   = 1'b0;
        if (accept) q0.push_back(d);
    endtask

    task automatic rd0(input string tag);
        logic [71:0] exp;
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        if (q0.size() == 0) begin
            check({tag, "_sb_empty"}, 72'd1, 72'd0);
        end else begin
            exp = q0.pop_front();
            last0 = exp;
            check(tag, rd_data0, exp);
        end
    endtask

    task automatic rw0(input logic [71:0] d, input string tag);
        logic [71:0] exp;
        wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = d;
        tick();
        wr_en0 = 1'b0; rd_en0 = 1'b0;
        exp = q0.pop_front();
        q0.push_back(d);
        check(tag, rd_data0, exp);
    endtask

    initial begin
        logic [71:0] w;
        // ---------------- reset, BOOT_COUNT = 0 ----------------
        tick(2);
        rst0_n = 1'b1;
        tick();
        check("rst_empty",   72'(rd_empty0), 72'd1);
        check("rst_count",   72'(rd_count0), 72'd0);
        check("rst_full",    72'(wr_full0),  72'd0);
        check("rst_afull",   72'(wr_af0),    72'd0);
        check("rst_rd_data", rd_data0,       72'd0);

        // ---------------- single word ----------------
        wr0(72'hAB_CDEF_0123_4567_89AB, 1'b1);
        check("one_empty_now", 72'(rd_empty0), 72'd1);
        tick(4);
        check("one_empty", 72'(rd_empty0), 72'd0);
        check("one_count", 72'(rd_count0), 72'd1);
        rd0("one_data");
        tick(4);
        check("one_empty_after", 72'(rd_empty0), 72'd1);
        check("one_count_after", 72'(rd_count0), 72'd0);

        // ---------------- fill 32 AA words ----------------
        for (int i = 0; i < 32; i++) begin
            wr0({8'hAA, 32'd0, 32'(i)}, 1'b1);
            if (i == 28) check("af_after_29", 72'(wr_af0),   72'd0);
            if (i == 29) check("af_after_30", 72'(wr_af0),   72'd1);
            if (i == 30) check("full_after_31", 72'(wr_full0), 72'd0);
            if (i == 31) check("full_after_32", 72'(wr_full0), 72'd1);
        end
        tick(3);
        check("fill_count", 72'(rd_count0), 72'd32);
        for (int i = 0; i < 32; i++) rd0("aa_data");
        check("aa_empty", 72'(rd_empty0), 72'd1);
        tick(4);
        check("aa_full_clear", 72'(wr_full0), 72'd0);

        // ---------------- overflow attempt ----------------
        for (int i = 0; i < 32; i++) wr0({8'hDD, 32'd0, 32'(i)}, 1'b1);
        check("dd_full", 72'(wr_full0), 72'd1);
        w = '1;
        wr0(w, 1'b0);
        check("ovf_full", 72'(wr_full0), 72'd1);
        tick(3);
        check("ovf_count", 72'(rd_count0), 72'd32);
        for (int i = 0; i < 32; i++) rd0("dd_data");
        check("dd_empty", 72'(rd_empty0), 72'd1);
        tick(4);
        check("dd_count", 72'(rd_count0), 72'd0);
        // read while empty: ignored, data holds
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        check("underflow_hold", rd_data0, last0);
        check("underflow_count", 72'(rd_count0), 72'd0);

        // ---------------- wrap-around with simultaneous read/write ----------------
        for (int i = 0; i < 10; i++) wr0({8'hBB, 32'd0, 32'(i)}, 1'b1);
        tick(3);
        for (int i = 0; i < 10; i++) rw0({8'hCC, 32'd0, 32'(i)}, "rw_data");
        tick(3);
        check("rw_count", 72'(rd_count0), 72'd10);
        for (int i = 0; i < 10; i++) rd0("cc_data");
        tick(4);
        check("cc_empty", 72'(rd_empty0), 72'd1);
        check("sb_drained", 72'(q0.size()), 72'd0);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 31; i++) wr0({8'hEE, 32'd0, 32'(i)}, 1'b0);
        tick(3);
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        #2 rst0_n = 1'b0;
        #1;
        check("midrst_empty", 72'(rd_empty0), 72'd1);
        check("midrst_count", 72'(rd_count0), 72'd0);
        check("midrst_afull", 72'(wr_af0),    72'd0);
        check("midrst_data",  rd_data0,       72'd0);
        tick();
        rst0_n = 1'b1;

        // ---------------- BOOT_COUNT = 5 ----------------
        rst5_n = 1'b1;
        tick();
        rst5_n = 1'b0;
        tick(2);
        rst5_n = 1'b1;
        tick();
        check("b5_empty", 72'(rd_empty5), 72'd0);
        check("b5_count", 72'(rd_count5), 72'd5);
        check("b5_full",  72'(wr_full5),  72'd0);
        check("b5_afull", 72'(wr_af5),    72'd0);
        wr_en5   = 1'b1;
        wr_data5 = 72'h55_AAAA_BBBB_CCCC_DDDD;
        tick();
        wr_en5   = 1'b0;
        tick(3);
        check("b5_count6", 72'(rd_count5), 72'd6);
        rd_en5 = 1'b1;
        tick(6);
        rd_en5 = 1'b0;
        check("b5_sixth", rd_data5, 72'h55_AAAA_BBBB_CCCC_DDDD);
        check("b5_empty_now", 72'(rd_empty5), 72'd1);
        check("b5_count0", 72'(rd_count5), 72'd0);
        tick(4);
        check("b5_empty_after", 72'(rd_empty5), 72'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- First-word-fall-through-free FIFO with registered read data and Gray-coded pointers.
- Pointers cross between the write side and the read side through 2-flop synchronizer stages, so the block can later be split onto separate clocks without changing its structure.
- Optional boot pre-population: after reset the FIFO already reports BOOT_COUNT valid entries. Used as the command FIFO between the SPI register front-end and the GPU core.

Parameters:
- WIDTH, 72, data word width in bits.
- DEPTH, 32, number of entries; must be a power of two and at least 4.
- BOOT_COUNT, 0, entries reported valid immediately after reset; range 0..DEPTH-1.
- ADDR_WIDTH (localparam), $clog2(DEPTH), memory address width.

Ports:
- clk  in  1  single clock for both sides; one clock, all logic on its rising edge.
- rst_n  in  1  reset, asynchronous assertion, active-low.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- wr_full  out  1  FIFO full.
- wr_almost_full  out  1  occupancy is at least DEPTH-2.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  registered read data.
- rd_empty  out  1  no readable entry.
- rd_count  out  ADDR_WIDTH+1  readable entry count.

Behaviour:
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide, kept in binary and Gray form. The MSB is the wrap bit.
- Reset values:
  - wr_ptr = BOOT_COUNT; rd_ptr = 0.
  - Both synchronizer stages hold the reset-time Gray value of the opposite pointer, so flags are correct in the first cycle after reset.
  - rd_data = 0.
  - rd_empty = (BOOT_COUNT==0).
  - rd_count = BOOT_COUNT.
  - wr_full = 0.
  - wr_almost_full = (BOOT_COUNT >= DEPTH-2).
- Write: on a rising edge with wr_en=1 and wr_full=0, store mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data and increment wr_ptr. A write while full is discarded: no pointer change, no memory change.
- Read: on a rising edge with rd_en=1 and rd_empty=0, load rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]] and increment rd_ptr. The data is valid after that edge (1-cycle latency). A read while empty is ignored and rd_data holds.
- Synchronizers:
  - Gray wr_ptr passes through 2 flops into the read side (wr_gray_sync).
  - Gray rd_ptr passes through 2 flops into the write side (rd_gray_sync).
  - Each synchronized pointer is converted back to binary.
- Write-side flags, combinational from the registered wr_ptr and rd_gray_sync:
  - wr_count = wr_ptr - rd_bin_sync.
  - wr_full = (wr_count == DEPTH), equivalent to the Gray compare with the top two bits inverted.
  - wr_almost_full = (wr_count >= DEPTH-2).
  - Both reflect a write on the very next edge.
- Read-side flags, from the registered rd_ptr and wr_gray_sync:
  - rd_count = wr_bin_sync - rd_ptr.
  - rd_empty = (rd_count == 0).
  - A write becomes visible on the read side 2 cycles after the write edge. A read frees space on the write side 2 cycles after the read edge. Flags are therefore conservative and never overstate availability.
- Wrap-around: pointers wrap modulo 2*DEPTH; all count subtractions are modulo 2^(ADDR_WIDTH+1).
- Simultaneous read and write in the same cycle: both are performed. Each side's flags update from its own pointer immediately and from the other pointer after the synchronizer delay.
- Memory:
  - Not cleared by reset; zero-initialized at configuration.
  - Boot entries mem[0..BOOT_COUNT-1] read as their current memory contents. After configuration that is 0.
  - The first post-reset write lands at mem[BOOT_COUNT].
- Reset mid-operation: immediately returns all pointers, synchronizers, flags and rd_data to their reset values. Stored data is lost logically.

Decomposition:
- No shared package is needed. Gray/binary conversion functions are local functions.
- One sub-module, gray_ptr_sync: a 2-flop synchronizer of an (ADDR_WIDTH+1)-bit Gray pointer with a parameterized reset value. It is instantiated twice.

Test Plan:
- Reset, BOOT_COUNT=0 -> rd_empty=1, rd_count=0, wr_full=0, wr_almost_full=0.
- Write 72'hAB_CDEF_0123_4567_89AB, wait 4 cycles -> rd_empty=0, rd_count=1. Then read -> rd_data equals the value on the next edge. After 4 more cycles -> rd_empty=1, rd_count=0.
- Write 32 words {8'hAA,32'b0,i}:
  - wr_almost_full=0 after 29 writes and 1 after 30.
  - wr_full=1 after 32 writes.
  - Reading all 32 returns i=0..31 in order, then rd_empty=1.
- Fill with {8'hDD,32'b0,i}, then write 72'hFF..FF while full -> wr_full stays 1. Draining returns only the 32 DD words.
- Prefill 10 BB words, then alternate read/write of CC words 10 times -> reads return BB0..9, then CC0..9, then rd_empty=1. This covers wrap-around.
- BOOT_COUNT=5 reset:
  - rd_empty=0, rd_count=5, wr_full=0, wr_almost_full=0.
  - Write 72'h55_AAAA_BBBB_CCCC_DDDD -> rd_count=6.
  - Six reads -> the sixth rd_data equals that word, then rd_empty=1 and rd_count=0.
